// File: rtl/sha_sched_pkg.sv
// Shared types and widths for the double-SHA nonce scheduler.
package sha_sched_pkg;

  localparam int unsigned NONCE_W    = 32;
  localparam int unsigned TAIL_WORDS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } SchedState;

  typedef struct packed {
    logic [TAIL_WORDS-1:0][NONCE_W-1:0] tail;
    logic [NONCE_W-1:0]                 start;
    logic [NONCE_W-1:0]                 count;
  } JobDesc;

  function automatic logic [NONCE_W-1:0] nonce_inc(input logic [NONCE_W-1:0] n);
    return n + NONCE_W'(1);
  endfunction

endpackage

// File: rtl/sha_sched_nonce_counter.sv
// Current nonce and nonces-remaining bookkeeping for one job.
module sha_sched_nonce_counter
  import sha_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [NONCE_W-1:0] start_i,
  input  logic [NONCE_W-1:0] count_i,
  input  logic               step_i,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               last_o
);

  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] remaining_q, remaining_d;

  always_comb begin
    nonce_d     = nonce_q;
    remaining_d = remaining_q;
    if (load_i) begin
      nonce_d     = start_i;
      remaining_d = count_i;
    end else if (step_i) begin
      // Wraps mod 2^32; remaining wrapping after the last step is harmless.
      nonce_d     = nonce_inc(nonce_q);
      remaining_d = remaining_q - NONCE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nonce_q     <= '0;
      remaining_q <= '0;
    end else begin
      nonce_q     <= nonce_d;
      remaining_q <= remaining_d;
    end
  end

  assign nonce_o = nonce_q;
  assign last_o  = (remaining_q == '0);

endmodule

// File: rtl/sha_last_nonce_scheduler.sv
// Issues one nonce per cycle for a latched mining job, then waits out the
// pipeline latency and pulses done.
module sha_last_nonce_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 130
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [TAIL_WORDS*NONCE_W-1:0]      job_tail_i,
  input  logic [NONCE_W-1:0]                 job_start_i,
  input  logic [NONCE_W-1:0]                 job_count_i,
  input  logic                               pause_i,
  input  logic                               abort_i,
  output logic [TAIL_WORDS*NONCE_W-1:0]      job_tail_o,
  output logic [NONCE_W-1:0]                 nonce_o,
  output logic                               valid_o,
  output logic                               newblock_o,
  output logic                               done_o
);

  localparam int unsigned DrainW = $clog2(LATENCY + 1);

  SchedState state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic pend_new_q, pend_new_d;
  logic job_ready_q, job_ready_d;
  logic valid_q, valid_d;
  logic newblock_q, newblock_d;
  logic done_q, done_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [TAIL_WORDS-1:0][NONCE_W-1:0] tail_q, tail_d;

  JobDesc job;
  logic accept;
  logic cnt_load, cnt_step, cnt_last;
  logic [NONCE_W-1:0] cnt_nonce;

  assign job = '{tail: job_tail_i, start: job_start_i, count: job_count_i};
  // Ready is only high in IDLE, so this also rejects jobs outside IDLE.
  assign accept = job_valid_i && job_ready_q;

  sha_sched_nonce_counter u_nonce_counter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load),
    .start_i (job.start),
    .count_i (job.count),
    .step_i  (cnt_step),
    .nonce_o (cnt_nonce),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pend_new_d  = pend_new_q;
    job_ready_d = job_ready_q;
    valid_d     = 1'b0;
    newblock_d  = 1'b0;
    done_d      = 1'b0;
    nonce_d     = nonce_q;
    tail_d      = tail_q;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        job_ready_d = 1'b1;
        if (accept) begin
          cnt_load    = 1'b1;
          tail_d      = job.tail;
          pend_new_d  = 1'b1;
          job_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          pend_new_d  = 1'b0;
          job_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (!pause_i) begin
          valid_d    = 1'b1;
          nonce_d    = cnt_nonce;
          newblock_d = pend_new_q;
          pend_new_d = 1'b0;
          cnt_step   = 1'b1;
          if (cnt_last) begin
            drain_d = DrainW'(LATENCY);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_i) begin
          drain_d     = '0;
          job_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (drain_q <= DrainW'(1)) begin
          // Ready stays low this cycle and rises after the done pulse.
          drain_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      pend_new_q  <= 1'b0;
      job_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      newblock_q  <= 1'b0;
      done_q      <= 1'b0;
      nonce_q     <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      pend_new_q  <= pend_new_d;
      job_ready_q <= job_ready_d;
      valid_q     <= valid_d;
      newblock_q  <= newblock_d;
      done_q      <= done_d;
      nonce_q     <= nonce_d;
      tail_q      <= tail_d;
    end
  end

  assign job_ready_o = job_ready_q;
  assign valid_o     = valid_q;
  assign newblock_o  = newblock_q;
  assign done_o      = done_q;
  assign nonce_o     = nonce_q;
  assign job_tail_o  = tail_q;

endmodule

// File: tb/tb_sha_last_nonce_scheduler.sv
// Bench for sha_last_nonce_scheduler: directed vectors, corner sequences and
// random traffic checked against a job-level reference model.
module tb_sha_last_nonce_scheduler;

  localparam int unsigned Lat = 130;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [95:0] job_tail_i;
  logic [31:0] job_start_i;
  logic [31:0] job_count_i;
  logic        pause_i;
  logic        abort_i;
  logic [95:0] job_tail_o;
  logic [31:0] nonce_o;
  logic        valid_o;
  logic        newblock_o;
  logic        done_o;

  always #5 clk = ~clk;

  sha_last_nonce_scheduler #(.LATENCY(Lat)) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid_i (job_valid_i),
    .job_ready_o (job_ready_o),
    .job_tail_i  (job_tail_i),
    .job_start_i (job_start_i),
    .job_count_i (job_count_i),
    .pause_i     (pause_i),
    .abort_i     (abort_i),
    .job_tail_o  (job_tail_o),
    .nonce_o     (nonce_o),
    .valid_o     (valid_o),
    .newblock_o  (newblock_o),
    .done_o      (done_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_last = 0;
  int t_done = 0;
  int n_done = 0;
  logic [31:0] vq[$];

  // Reference model: a job is "total" nonces, issued one by one; done is
  // scheduled at an absolute cycle number once the last nonce goes out.
  bit          m_active, m_ready, m_valid, m_nb, m_done;
  logic [31:0] m_nonce, m_start;
  logic [95:0] m_tail;
  longint      m_total, m_issued, m_done_at;

  function automatic void model_reset();
    m_active = 0; m_ready = 1; m_valid = 0; m_nb = 0; m_done = 0;
    m_nonce = '0; m_start = '0; m_tail = '0;
    m_total = 0; m_issued = 0; m_done_at = -1;
  endfunction

  function automatic void model_edge();
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    m_valid = 0; m_nb = 0; m_done = 0;
    if (!m_active) begin
      if (job_valid_i && m_ready) begin
        m_active = 1; m_ready = 0;
        m_tail = job_tail_i; m_start = job_start_i;
        m_total = longint'(job_count_i) + 1; m_issued = 0;
      end else begin
        m_ready = 1;
      end
    end else if (abort_i) begin
      m_active = 0; m_ready = 1;
    end else if (m_issued < m_total) begin
      if (!pause_i) begin
        m_valid = 1;
        m_nb = (m_issued == 0);
        m_nonce = m_start + 32'(m_issued);
        m_issued++;
        if (m_issued == m_total) m_done_at = cyc + Lat;
      end
    end else if (cyc == m_done_at) begin
      m_done = 1; m_active = 0; m_ready = 0;
    end
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("m_valid", 128'(valid_o), 128'(m_valid));
    check("m_nonce", 128'(nonce_o), 128'(m_nonce));
    check("m_newblock", 128'(newblock_o), 128'(m_nb));
    check("m_done", 128'(done_o), 128'(m_done));
    check("m_ready", 128'(job_ready_o), 128'(m_ready));
    check("m_tail", 128'(job_tail_o), 128'(m_tail));
    if (valid_o === 1'b1) begin
      t_last = cyc;
      vq.push_back(nonce_o);
    end
    if (done_o === 1'b1) begin
      t_done = cyc;
      n_done++;
    end
  endtask

  task automatic idle_inputs();
    job_valid_i = 0; pause_i = 0; abort_i = 0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0 = n_done;
    int i  = 0;
    while (n_done == d0 && i < bound) begin
      tick();
      i++;
    end
    check(name, 128'(n_done - d0), 128'd1);
  endtask

  typedef struct {
    logic        jv;
    logic [31:0] start;
    logic [31:0] count;
    logic        pause;
    logic        valid;
    logic [31:0] nonce;
    logic        nb;
    logic        ready;
  } vec_t;

  vec_t tv[6];

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [95:0] tail_a;

    tv[0] = '{1'b1, 32'h10, 32'd3, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tv[1] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0};
    tv[2] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0};
    tv[3] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b1, 32'h12, 1'b0, 1'b0};
    tv[4] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0};
    tv[5] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 32'h13, 1'b0, 1'b0};

    rst = 1; idle_inputs();
    job_tail_i = 96'h0123_4567_89ab_cdef_fedc_ba98; job_start_i = '0; job_count_i = '0;
    model_reset();
    tick();
    tick();
    check("reset_ready", 128'(job_ready_o), 128'd1);
    check("reset_valid", 128'(valid_o), 128'd0);
    check("reset_nonce", 128'(nonce_o), 128'd0);
    check("reset_tail", 128'(job_tail_o), 128'd0);
    rst = 0;

    // Basic job: 0x10..0x13
    for (int i = 0; i < 6; i++) begin
      job_valid_i = tv[i].jv; job_start_i = tv[i].start;
      job_count_i = tv[i].count; pause_i = tv[i].pause;
      tick();
      check("t1_valid", 128'(valid_o), 128'(tv[i].valid));
      check("t1_nonce", 128'(nonce_o), 128'(tv[i].nonce));
      check("t1_newblock", 128'(newblock_o), 128'(tv[i].nb));
      check("t1_ready", 128'(job_ready_o), 128'(tv[i].ready));
    end
    check("t1_tail", 128'(job_tail_o), 128'(96'h0123_4567_89ab_cdef_fedc_ba98));
    wait_done("t1_done_seen", Lat + 10);
    check("t1_latency", 128'(t_done - t_last), 128'(Lat));
    tick();
    check("t1_ready_after", 128'(job_ready_o), 128'd1);

    // Nonce wrap
    vq.delete();
    d0 = n_done;
    job_valid_i = 1; job_start_i = 32'hFFFF_FFFE; job_count_i = 2;
    tick();
    idle_inputs();
    wait_done("t2_done_seen", Lat + 20);
    repeat (5) tick();
    check("t2_count", 128'(vq.size()), 128'd3);
    if (vq.size() == 3) begin
      check("t2_n0", 128'(vq[0]), 128'(32'hFFFF_FFFE));
      check("t2_n1", 128'(vq[1]), 128'(32'hFFFF_FFFF));
      check("t2_n2", 128'(vq[2]), 128'(32'h0000_0000));
    end
    check("t2_one_done", 128'(n_done - d0), 128'd1);

    // Pause from the acceptance cycle
    vq.delete();
    job_valid_i = 1; job_start_i = 5; job_count_i = 1; pause_i = 1;
    tick();
    job_valid_i = 0;
    tick();
    tick();
    check("t3_no_valid_paused", 128'(vq.size()), 128'd0);
    pause_i = 0;
    tick();
    check("t3_first_nonce", 128'({valid_o, newblock_o, nonce_o}), 128'({2'b11, 32'd5}));
    tick();
    check("t3_second_nonce", 128'({valid_o, newblock_o, nonce_o}), 128'({2'b10, 32'd6}));
    wait_done("t3_done_seen", Lat + 10);
    check("t3_latency", 128'(t_done - t_last), 128'(Lat));
    tick();

    // Abort in ISSUE, then a fresh job
    job_valid_i = 1; job_start_i = 32'h20; job_count_i = 9;
    tick();
    job_valid_i = 0;
    tick();
    tick();
    abort_i = 1;
    tick();
    abort_i = 0;
    check("t4_abort_valid", 128'(valid_o), 128'd0);
    check("t4_abort_ready", 128'(job_ready_o), 128'd1);
    d0 = n_done;
    repeat (Lat + 10) tick();
    check("t4_no_done", 128'(n_done - d0), 128'd0);
    job_valid_i = 1; job_start_i = 32'h100; job_count_i = 0;
    tick();
    job_valid_i = 0;
    tick();
    check("t4_new_job", 128'({valid_o, newblock_o, nonce_o}), 128'({2'b11, 32'h100}));
    wait_done("t4_done_seen", Lat + 10);
    tick();

    // job_valid held during ISSUE is ignored; abort in DRAIN
    tail_a = 96'haaaa_0000_bbbb_1111_cccc_2222;
    job_tail_i = tail_a; job_valid_i = 1; job_start_i = 32'h40; job_count_i = 5;
    tick();
    job_tail_i = 96'h5555_5555_5555_5555_5555_5555; job_start_i = 32'h999;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_tail_hold", 128'(job_tail_o), 128'(tail_a));
    end
    job_valid_i = 0;
    repeat (5) tick();
    abort_i = 1;
    tick();
    abort_i = 0;
    check("t5_abort_ready", 128'(job_ready_o), 128'd1);
    d0 = n_done;
    repeat (Lat + 10) tick();
    check("t5_no_done", 128'(n_done - d0), 128'd0);
    check("t5_tail_after", 128'(job_tail_o), 128'(tail_a));

    // Asynchronous reset between edges
    job_valid_i = 1; job_start_i = 32'h500; job_count_i = 50;
    tick();
    job_valid_i = 0;
    tick();
    tick();
    #2 rst = 1;
    #1;
    check("t6_rst_valid", 128'(valid_o), 128'd0);
    check("t6_rst_ready", 128'(job_ready_o), 128'd1);
    check("t6_rst_nonce", 128'(nonce_o), 128'd0);
    check("t6_rst_tail", 128'(job_tail_o), 128'd0);
    model_reset();
    tick();
    rst = 0;
    tick();
    check("t6_post_ready", 128'(job_ready_o), 128'd1);
    check("t6_post_valid", 128'(valid_o), 128'd0);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      job_valid_i = ($urandom_range(0, 2) == 0);
      job_tail_i  = {$urandom, $urandom, $urandom};
      job_start_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4)))
                                                : $urandom;
      job_count_i = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
      pause_i     = ($urandom_range(0, 3) == 0);
      abort_i     = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
